// File: rtl/mux_nto1_rr_if.sv
// Handshake bundle between N producer streams, the mux, and one consumer.
// The master side drives inputs and consumer ready; the slave side is the mux.
interface mux_nto1_rr_if #(
    parameter int N = 4,
    parameter int W = 4
);
    localparam int SELW = $clog2(N);

    logic                mode;
    logic [SELW-1:0]     sel;
    logic [N*W-1:0]      in_data;
    logic [N-1:0]        in_valid;
    logic [N-1:0]        in_ready;
    logic [W-1:0]        out_data;
    logic [SELW-1:0]     out_ch;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux_nto1_rr.sv
// N:1 registered mux, fixed-select or round-robin; 1 cycle from input transfer to out_valid.
// Backpressure: the output register reloads only when empty or draining; otherwise every in_ready is low.
module mux_nto1_rr #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_nto1_rr_if.slave  bus
);
    localparam int SELW = $clog2(N);

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] gnt_idx;
    logic            granted;
    logic            load_en;
    logic [N-1:0]    rdy;
    logic [W-1:0]    data_q;
    logic [SELW-1:0] ch_q;
    logic            vld_q;
    int              c;

    assign load_en = ~vld_q | bus.out_ready;

    // Round-robin scans from the far end so the last hit is the first channel after ptr.
    always_comb begin
        gnt_idx = '0;
        granted = 1'b0;
        c       = 0;
        if (!bus.mode) begin
            for (int k = 0; k < N; k++) begin
                if (SELW'(k) == bus.sel && bus.in_valid[SELW'(k)]) begin
                    granted = 1'b1;
                    gnt_idx = SELW'(k);
                end
            end
        end else begin
            for (int i = N; i >= 1; i--) begin
                c = (int'(ptr) + i) % N;
                if (bus.in_valid[SELW'(c)]) begin
                    granted = 1'b1;
                    gnt_idx = SELW'(c);
                end
            end
        end
    end

    always_comb begin
        rdy = '0;
        if (load_en && granted && rst_n) begin
            rdy[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            ch_q   <= '0;
            vld_q  <= 1'b0;
            ptr    <= SELW'(N - 1);
        end else if (load_en) begin
            if (granted) begin
                data_q <= bus.in_data[int'(gnt_idx)*W +: W];
                ch_q   <= gnt_idx;
                vld_q  <= 1'b1;
                if (bus.mode) begin
                    ptr <= gnt_idx;
                end
            end else begin
                vld_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
    assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_mux_nto1_rr.sv
// Directed bench for mux_nto1_rr: a 4-channel instance plus a 3-channel instance
// for the out-of-range select case.
module tb_mux_nto1_rr;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mux_nto1_rr_if #(.N(4), .W(4)) bus ();
    mux_nto1_rr_if #(.N(3), .W(4)) bus3 ();

    mux_nto1_rr #(.N(4), .W(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    mux_nto1_rr #(.N(3), .W(4)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.mode = 1'b1; bus.sel = 2'd0; bus.in_data = 16'h4321;
        bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        bus3.mode = 1'b0; bus3.sel = 2'd0; bus3.in_data = 12'h321;
        bus3.in_valid = 3'b000; bus3.out_ready = 1'b1;
        rst_n = 1'b0;
        #2;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0h expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data: got %0h expected 0", bus.out_data); end
        checks++; if (bus.out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch: got %0h expected 0", bus.out_ch); end
        checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b expected 0000", bus.in_ready); end
        tick();
        tick();
        rst_n = 1'b1;
        bus.in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_fixed();
        bus.mode = 1'b0; bus.sel = 2'd2; bus.in_data = 16'h0A00;
        bus.in_valid = 4'b0100; bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_in_ready: got %b expected 0100", bus.in_ready); end
        tick();
        bus.in_valid = 4'b0000;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL fixed_out_valid: got %0h expected 1", bus.out_valid); end
        checks++; if (bus.out_data !== 4'hA) begin errors++; $display("FAIL fixed_out_data: got %0h expected a", bus.out_data); end
        checks++; if (bus.out_ch !== 2'd2) begin errors++; $display("FAIL fixed_out_ch: got %0d expected 2", bus.out_ch); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fixed_idle_valid: got %0h expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== 4'hA) begin errors++; $display("FAIL fixed_idle_hold: got %0h expected a", bus.out_data); end
    endtask

    task automatic test_backpressure();
        bus.mode = 1'b0; bus.sel = 2'd1; bus.in_data = 16'h4321;
        bus.in_valid = 4'b1111; bus.out_ready = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 4'b0010) begin errors++; $display("FAIL bp_fill_ready: got %b expected 0010", bus.in_ready); end
        tick();
        bus.sel = 2'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0000", i, bus.in_ready); end
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h2 || bus.out_ch !== 2'd1) begin
                errors++; $display("FAIL bp_hold[%0d]: got v=%0h d=%0h ch=%0d expected v=1 d=2 ch=1", i, bus.out_valid, bus.out_data, bus.out_ch);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_ready: got %b expected 1000", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h4 || bus.out_ch !== 2'd3) begin
            errors++; $display("FAIL bp_no_bubble: got v=%0h d=%0h ch=%0d expected v=1 d=4 ch=3", bus.out_valid, bus.out_data, bus.out_ch);
        end
        bus.in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_rr_fair();
        logic [1:0] exp_ch [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        bus.mode = 1'b1; bus.in_data = 16'h4321; bus.in_valid = 4'b0000; bus.out_ready = 1'b1;
        do_reset();
        bus.in_valid = 4'b1111;
        #1;
        checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL rr_first_ready: got %b expected 0001", bus.in_ready); end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== exp_ch[i] || bus.out_data !== 4'(exp_ch[i]) + 4'd1) begin
                errors++; $display("FAIL rr_fair[%0d]: got v=%0h ch=%0d d=%0h expected v=1 ch=%0d d=%0h",
                                   i, bus.out_valid, bus.out_ch, bus.out_data, exp_ch[i], 4'(exp_ch[i]) + 4'd1);
            end
        end
    endtask

    task automatic test_rr_sparse();
        logic [1:0] exp_ch [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
        bus.mode = 1'b1; bus.in_data = 16'h4321; bus.in_valid = 4'b0000; bus.out_ready = 1'b1;
        do_reset();
        bus.in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== exp_ch[i] || bus.out_data !== 4'(exp_ch[i]) + 4'd1) begin
                errors++; $display("FAIL rr_sparse[%0d]: got v=%0h ch=%0d d=%0h expected v=1 ch=%0d d=%0h",
                                   i, bus.out_valid, bus.out_ch, bus.out_data, exp_ch[i], 4'(exp_ch[i]) + 4'd1);
            end
        end
        bus.in_valid = 4'b0000;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rr_sparse_idle: got %0h expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== 4'h4 || bus.out_ch !== 2'd3) begin
            errors++; $display("FAIL rr_sparse_hold: got d=%0h ch=%0d expected d=4 ch=3", bus.out_data, bus.out_ch);
        end
    endtask

    task automatic test_fixed_illegal();
        bus.mode = 1'b0; bus.sel = 2'd0; bus.in_data = 16'h4321;
        bus.in_valid = 4'b1101; bus.out_ready = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0) begin
            errors++; $display("FAIL idle_fill: got v=%0h ch=%0d expected v=1 ch=0", bus.out_valid, bus.out_ch);
        end
        bus.sel = 2'd1;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL idle_in_ready: got %b expected 0000", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.out_ch !== 2'd0) begin
            errors++; $display("FAIL idle_drain: got v=%0h ch=%0d expected v=0 ch=0", bus.out_valid, bus.out_ch);
        end
        bus.in_valid = 4'b0000;
        bus3.mode = 1'b0; bus3.sel = 2'd3; bus3.in_valid = 3'b111; bus3.out_ready = 1'b1;
        #1;
        checks++; if (bus3.in_ready !== 3'b000) begin errors++; $display("FAIL n3_sel3_ready: got %b expected 000", bus3.in_ready); end
        tick();
        checks++; if (bus3.out_valid !== 1'b0) begin errors++; $display("FAIL n3_sel3_valid: got %0h expected 0", bus3.out_valid); end
        bus3.sel = 2'd2;
        #1;
        checks++; if (bus3.in_ready !== 3'b100) begin errors++; $display("FAIL n3_sel2_ready: got %b expected 100", bus3.in_ready); end
        tick();
        checks++; if (bus3.out_valid !== 1'b1 || bus3.out_ch !== 2'd2 || bus3.out_data !== 4'h3) begin
            errors++; $display("FAIL n3_sel2_out: got v=%0h ch=%0d d=%0h expected v=1 ch=2 d=3", bus3.out_valid, bus3.out_ch, bus3.out_data);
        end
        bus3.in_valid = 3'b000;
    endtask

    task automatic test_reset_mid();
        bus.mode = 1'b1; bus.in_data = 16'h4321; bus.in_valid = 4'b1111; bus.out_ready = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %0h expected 1", bus.out_valid); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 || bus.out_ch !== 2'd0) begin
            errors++; $display("FAIL mid_async_clear: got v=%0h d=%0h ch=%0d expected 0 0 0", bus.out_valid, bus.out_data, bus.out_ch);
        end
        checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL mid_in_ready: got %b expected 0000", bus.in_ready); end
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_ready: got %b expected 0001", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0 || bus.out_data !== 4'h1) begin
            errors++; $display("FAIL mid_first_grant: got v=%0h ch=%0d d=%0h expected v=1 ch=0 d=1", bus.out_valid, bus.out_ch, bus.out_data);
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_backpressure();
        test_rr_fair();
        test_rr_sparse();
        test_fixed_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
